// File: rtl/usxgmii_pkt_gen_pkg.sv
// Shared types and constants for the USXGMII TX frame generator.
// Holds the frame byte map used by the beat builder.
package usxgmii_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int BYTES_PER_BEAT = 8;
    localparam int DA_OFF         = 0;
    localparam int SA_OFF         = 6;
    localparam int ET_OFF         = 12;
    localparam int PAY_OFF        = 14;

    // Byte b of a frame of length len; bytes past the end read as zero.
    function automatic logic [7:0] frame_byte(
        input logic [13:0] b,
        input logic [13:0] len,
        input logic [47:0] da,
        input logic [47:0] sa,
        input logic [15:0] et
    );
        logic [7:0] r;
        int         i;
        i = int'(b);
        if (b >= len)
            r = 8'h00;
        else if (i < SA_OFF)
            r = 8'(da >> (8 * (SA_OFF - 1 - (i - DA_OFF))));
        else if (i < ET_OFF)
            r = 8'(sa >> (8 * (ET_OFF - 1 - i)));
        else if (i < PAY_OFF)
            r = 8'(et >> (8 * (PAY_OFF - 1 - i)));
        else
            r = 8'(i - PAY_OFF);
        return r;
    endfunction

endpackage

// File: rtl/usxgmii_tx_beat_builder.sv
// Combinational builder for one 64-bit Avalon-ST beat of a frame.
// Byte 0 of the beat lands in data[63:56].
module usxgmii_tx_beat_builder
    import usxgmii_pkt_gen_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic [10:0] beat_idx,
    input  logic [13:0] len,
    input  logic [47:0] da,
    input  logic [47:0] sa,
    output logic [63:0] data,
    output logic [2:0]  empty,
    output logic        eop
);

    logic [13:0] base;

    assign base = {beat_idx, 3'b000};

    always_comb begin
        data = '0;
        for (int k = 0; k < BYTES_PER_BEAT; k++) begin
            data[63-8*k -: 8] = frame_byte(base + 14'(k), len, da, sa, ETHERTYPE);
        end
    end

    assign eop   = ({1'b0, base} + 15'd8) >= {1'b0, len};
    assign empty = eop ? (3'd0 - len[2:0]) : 3'd0;

endmodule

// File: rtl/usxgmii_tx_pkt_gen.sv
// Ethernet test-frame generator on the MAC Avalon-ST TX interface.
// FSM, frame counters and the registered output beat live here.
module usxgmii_tx_pkt_gen
    import usxgmii_pkt_gen_pkg::*;
#(
    parameter int          MIN_LEN    = 64,
    parameter int          MAX_LEN    = 9600,
    parameter int          GAP_CYCLES = 0,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic        tx_156_25_clk,
    input  logic        tx_rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] pkt_count_cfg,
    input  logic [13:0] pkt_len_cfg,
    input  logic [47:0] dest_mac,
    input  logic [47:0] src_mac,
    output logic        busy,
    output logic        done,
    output logic [31:0] pkts_sent,
    output logic        avalon_st_tx_valid,
    output logic        avalon_st_tx_startofpacket,
    output logic        avalon_st_tx_endofpacket,
    output logic [63:0] avalon_st_tx_data,
    output logic [2:0]  avalon_st_tx_empty,
    output logic        avalon_st_tx_error,
    input  logic        avalon_st_tx_ready
);

    localparam logic [13:0] MIN_L    = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L    = 14'(MAX_LEN);
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e      state;
    logic [13:0] len_q;
    logic [11:0] nbeats_q;
    logic [11:0] beat_idx;
    logic [47:0] da_q;
    logic [47:0] sa_q;
    logic [31:0] frames_left;
    logic        cont_q;
    logic        stop_pend;
    logic [15:0] gap_cnt;
    logic        done_q;
    logic [31:0] pkts_q;

    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [63:0] out_data;
    logic [2:0]  out_empty;

    logic [13:0] len_clamp;
    logic [11:0] nbeats_calc;
    logic        accept;
    logic        eop_acc;
    logic        can_load;
    logic        start_ok;
    logic        stop_now;
    logic        last_frm;
    logic        finish;
    logic        gap_end;
    logic        ld_first;
    logic        ld_next;
    logic        load;
    logic [11:0] bb_idx;
    logic [63:0] bb_data;
    logic [2:0]  bb_empty;
    logic        bb_eop;

    assign len_clamp = (pkt_len_cfg < MIN_L) ? MIN_L :
                       (pkt_len_cfg > MAX_L) ? MAX_L : pkt_len_cfg;

    assign nbeats_calc = 12'((15'(len_clamp) + 15'd7) >> 3);

    assign accept   = out_valid & avalon_st_tx_ready;
    assign eop_acc  = accept & out_eop;
    assign can_load = ~out_valid | accept;
    // A start coinciding with done is dropped: the run is still closing.
    assign start_ok = (state == IDLE) & start & ~done_q;
    assign stop_now = stop_pend | stop;
    assign last_frm = ~cont_q & (frames_left == 32'd1);
    assign finish   = eop_acc & (last_frm | stop_now);
    assign gap_end  = (state == GAP) & (gap_cnt == GAP_LAST);

    // The next frame's SOP is loaded on the edge that retires the
    // previous EOP or ends the gap, so no bubble is inserted.
    assign ld_first = ((state == SEND) & eop_acc & ~finish & (GAP_CYCLES == 0))
                    | (gap_end & ~stop_now);
    assign ld_next  = (state == SEND) & can_load & (beat_idx != nbeats_q);
    assign load     = ld_first | ld_next;
    assign bb_idx   = ld_first ? 12'd0 : beat_idx;

    usxgmii_tx_beat_builder #(
        .ETHERTYPE (ETHERTYPE)
    ) u_beat (
        .beat_idx (bb_idx[10:0]),
        .len      (len_q),
        .da       (da_q),
        .sa       (sa_q),
        .data     (bb_data),
        .empty    (bb_empty),
        .eop      (bb_eop)
    );

    always_ff @(posedge tx_156_25_clk) begin
        if (tx_rst) begin
            state       <= IDLE;
            len_q       <= '0;
            nbeats_q    <= '0;
            beat_idx    <= '0;
            da_q        <= '0;
            sa_q        <= '0;
            frames_left <= '0;
            cont_q      <= 1'b0;
            stop_pend   <= 1'b0;
            gap_cnt     <= '0;
            done_q      <= 1'b0;
            pkts_q      <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_data    <= '0;
            out_empty   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state       <= SEND;
                        len_q       <= len_clamp;
                        nbeats_q    <= nbeats_calc;
                        beat_idx    <= '0;
                        da_q        <= dest_mac;
                        sa_q        <= src_mac;
                        frames_left <= pkt_count_cfg;
                        cont_q      <= (pkt_count_cfg == 32'd0);
                        stop_pend   <= 1'b0;
                        pkts_q      <= '0;
                    end
                end
                SEND: begin
                    if (stop)
                        stop_pend <= 1'b1;
                    if (eop_acc) begin
                        pkts_q <= pkts_q + 32'd1;
                        if (!cont_q)
                            frames_left <= frames_left - 32'd1;
                        if (finish) begin
                            state     <= IDLE;
                            done_q    <= 1'b1;
                            stop_pend <= 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (stop_now) begin
                        state     <= IDLE;
                        done_q    <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (gap_end) begin
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                out_valid <= 1'b1;
                out_sop   <= (bb_idx == 12'd0);
                out_eop   <= bb_eop;
                out_data  <= bb_data;
                out_empty <= bb_empty;
                beat_idx  <= bb_idx + 12'd1;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_sop   <= 1'b0;
                out_eop   <= 1'b0;
                out_data  <= '0;
                out_empty <= '0;
            end
        end
    end

    assign busy                       = (state != IDLE);
    assign done                       = done_q;
    assign pkts_sent                  = pkts_q;
    assign avalon_st_tx_valid         = out_valid;
    assign avalon_st_tx_startofpacket = out_sop;
    assign avalon_st_tx_endofpacket   = out_eop;
    assign avalon_st_tx_data          = out_data;
    assign avalon_st_tx_empty         = out_empty;
    assign avalon_st_tx_error         = 1'b0;

endmodule

// File: tb/tb_usxgmii_tx_pkt_gen.sv
// Directed bench for usxgmii_tx_pkt_gen: frame content, handshake,
// clamping, stop and mid-frame reset.
module tb_usxgmii_tx_pkt_gen;

    localparam logic [47:0] DA = 48'h0123_4567_89AB;
    localparam logic [47:0] SA = 48'hCAFE_F00D_BEEF;

    logic        clk = 1'b0;
    logic        tx_rst;
    logic        start;
    logic        stop;
    logic [31:0] pkt_count_cfg;
    logic [13:0] pkt_len_cfg;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic        busy;
    logic        done;
    logic [31:0] pkts_sent;
    logic        avalon_st_tx_valid;
    logic        avalon_st_tx_startofpacket;
    logic        avalon_st_tx_endofpacket;
    logic [63:0] avalon_st_tx_data;
    logic [2:0]  avalon_st_tx_empty;
    logic        avalon_st_tx_error;
    logic        avalon_st_tx_ready;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #3 clk = ~clk;

    usxgmii_tx_pkt_gen dut (
        .tx_156_25_clk              (clk),
        .tx_rst                     (tx_rst),
        .start                      (start),
        .stop                       (stop),
        .pkt_count_cfg              (pkt_count_cfg),
        .pkt_len_cfg                (pkt_len_cfg),
        .dest_mac                   (dest_mac),
        .src_mac                    (src_mac),
        .busy                       (busy),
        .done                       (done),
        .pkts_sent                  (pkts_sent),
        .avalon_st_tx_valid         (avalon_st_tx_valid),
        .avalon_st_tx_startofpacket (avalon_st_tx_startofpacket),
        .avalon_st_tx_endofpacket   (avalon_st_tx_endofpacket),
        .avalon_st_tx_data          (avalon_st_tx_data),
        .avalon_st_tx_empty         (avalon_st_tx_empty),
        .avalon_st_tx_error         (avalon_st_tx_error),
        .avalon_st_tx_ready         (avalon_st_tx_ready)
    );

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int clampl(input int r);
        return (r < 64) ? 64 : ((r > 9600) ? 9600 : r);
    endfunction

    function automatic logic [7:0] exp_byte(input int b, input int len);
        logic [47:0] dv;
        logic [47:0] sv;
        dv = DA;
        sv = SA;
        if (b >= len) return 8'h00;
        if (b < 6) return dv[47-8*b -: 8];
        if (b < 12) return sv[47-8*(b-6) -: 8];
        if (b == 12) return 8'h88;
        if (b == 13) return 8'hB5;
        return 8'((b - 14) % 256);
    endfunction

    // {sop, eop, empty, error, data}
    function automatic logic [69:0] exp_beat(input int len, input int beat, input int nb);
        logic [63:0] d;
        logic        e;
        logic [2:0]  em;
        for (int k = 0; k < 8; k++) d[63-8*k -: 8] = exp_byte(beat * 8 + k, len);
        e  = (beat == nb - 1);
        em = e ? 3'((8 - len % 8) % 8) : 3'd0;
        return {(beat == 0), e, em, 1'b0, d};
    endfunction

    function automatic logic [69:0] obs_beat();
        return {avalon_st_tx_startofpacket, avalon_st_tx_endofpacket,
                avalon_st_tx_empty, avalon_st_tx_error, avalon_st_tx_data};
    endfunction

    task automatic run(input int len_req, input int cnt, input bit rnd,
                       input int stop_frame, input int exp_frames);
        int len, nb, frame, beat, cycles, budget;
        bit done_seen, stop_sent, rdy;
        len       = clampl(len_req);
        nb        = (len + 7) / 8;
        budget    = nb * exp_frames * (rnd ? 6 : 1) + 64;
        frame     = 0;
        beat      = 0;
        cycles    = 0;
        done_seen = 0;
        stop_sent = 0;
        avalon_st_tx_ready = 1'b1;
        pkt_len_cfg   = 14'(len_req);
        pkt_count_cfg = 32'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 70'(busy), 70'(1));
        chk("pkts_cleared", 70'(pkts_sent), 70'(0));
        chk("valid_before_sop", 70'(avalon_st_tx_valid), 70'(0));
        @(negedge clk);
        chk("sop_latency", 70'({avalon_st_tx_valid, avalon_st_tx_startofpacket}), 70'(3));
        while (!done_seen && cycles < budget) begin
            stop = 1'b0;
            rdy  = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            avalon_st_tx_ready = rdy;
            if (frame < exp_frames)
                chk("valid_in_run", 70'(avalon_st_tx_valid), 70'(1));
            if (avalon_st_tx_valid) begin
                chk($sformatf("beat_f%0d_b%0d", frame, beat), obs_beat(), exp_beat(len, beat, nb));
                if (rdy) begin
                    if (!stop_sent && stop_frame > 0 && frame == stop_frame - 1 && beat == 3) begin
                        stop = 1'b1;
                        stop_sent = 1;
                    end
                    if (beat == nb - 1) begin
                        frame++;
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            if (done) begin
                done_seen = 1;
                chk("busy_low_with_done", 70'(busy), 70'(0));
                chk("pkts_sent", 70'(pkts_sent), 70'(exp_frames));
            end
            @(negedge clk);
            cycles++;
        end
        stop = 1'b0;
        avalon_st_tx_ready = 1'b1;
        chk("done_seen", 70'(done_seen), 70'(1));
        chk("frames", 70'(frame), 70'(exp_frames));
        chk("done_single", 70'(done), 70'(0));
        chk("idle_after", 70'({busy, avalon_st_tx_valid}), 70'(0));
    endtask

    initial begin
        tx_rst             = 1'b1;
        start              = 1'b0;
        stop               = 1'b0;
        pkt_count_cfg      = '0;
        pkt_len_cfg        = '0;
        dest_mac           = DA;
        src_mac            = SA;
        avalon_st_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 70'({avalon_st_tx_valid, avalon_st_tx_startofpacket,
                             avalon_st_tx_endofpacket, avalon_st_tx_empty,
                             avalon_st_tx_error, busy, done}), 70'(0));
        chk("rst_data", 70'(avalon_st_tx_data), 70'(0));
        chk("rst_pkts", 70'(pkts_sent), 70'(0));
        tx_rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 70'({busy, avalon_st_tx_valid}), 70'(0));

        run(64, 1, 1'b0, 0, 1);
        run(67, 3, 1'b0, 0, 3);
        run(1500, 10, 1'b1, 0, 10);
        run(20, 1, 1'b0, 0, 1);
        run(16000, 1, 1'b0, 0, 1);
        run(100, 0, 1'b0, 3, 3);

        pkt_len_cfg   = 14'd64;
        pkt_count_cfg = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_beat", obs_beat(), exp_beat(64, 4, 8));
        chk("pre_rst_valid", 70'(avalon_st_tx_valid), 70'(1));
        chk("pre_rst_pkts", 70'(pkts_sent), 70'(1));
        tx_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 70'(avalon_st_tx_valid), 70'(0));
        chk("mid_rst_pkts", 70'(pkts_sent), 70'(0));
        chk("mid_rst_busy", 70'(busy), 70'(0));
        tx_rst = 1'b0;
        @(negedge clk);
        run(64, 1, 1'b0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
